// File: rtl/codec_pkg.sv
// codec_pkg: shared definitions for the codec ADC receive path.
//  - SAMPLE_WIDTH_DEF : default bits per channel word
//  - rx_state_t       : receive FSM states (IDLE, SKIP, SHIFT, HOLD)
//  - CH_LEFT/CH_RIGHT : channel encoding, equal to the ADCLRCK level of that channel
`timescale 1ns/1ps
package codec_pkg;

  localparam int SAMPLE_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } rx_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/codec_sync_edge.sv
// codec_sync_edge: multi-flop synchronizer for one asynchronous codec pin,
// followed by a rise/fall detector in the clk domain.
// Ports:
//  clk, rst : system clock, asynchronous active-high reset
//  din      : asynchronous input pin
//  dout     : synchronized level
//  rise     : 1-cycle pulse when dout goes 0->1
//  fall     : 1-cycle pulse when dout goes 1->0
`timescale 1ns/1ps
module codec_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= din;
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_reg <= 1'b0;
    else     prev_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign dout = sync_reg[SYNC_STAGES-1];
  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/codec_adc_receiver.sv
// codec_adc_receiver: I2S slave receiver for the codec ADC stream. Deserializes
// left/right words and presents signed stereo frames on a valid/ready interface.
// Optional feature macro: LEVEL_METER_EN (adds peak_level/peak_rd peak meter).
// Ports:
//  clk, rst                 : system clock, asynchronous active-high reset
//  enable                   : 0 holds the receiver in IDLE
//  aud_bclk/adclrck/adcdat  : asynchronous codec I2S pins
//  frame_left/right/valid   : output frame, held while valid && !ready
//  frame_ready              : consumer accept
//  overrun / overrun_clr    : sticky dropped-frame flag and its clear pulse
//  short_word               : pulse when a word was cut short by an LRCK edge
//  peak_level / peak_rd     : (LEVEL_METER_EN) max |sample| window, read-and-clear
`timescale 1ns/1ps
module codec_adc_receiver
  import codec_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int I2S_DELAY    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    aud_bclk,
  input  logic                    aud_adclrck,
  input  logic                    aud_adcdat,
  output logic [SAMPLE_WIDTH-1:0] frame_left,
  output logic [SAMPLE_WIDTH-1:0] frame_right,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun,
  input  logic                    overrun_clr,
  output logic                    short_word
`ifdef LEVEL_METER_EN
  ,
  output logic [SAMPLE_WIDTH-1:0] peak_level,
  input  logic                    peak_rd
`endif
);

  localparam int CNT_W  = $clog2(SAMPLE_WIDTH + 1);
  localparam int SKIP_W = (I2S_DELAY < 1) ? 1 : $clog2(I2S_DELAY + 1);
  localparam logic [SAMPLE_WIDTH-1:0] MSB_MASK = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  // ---------------- pin synchronizers ----------------
  logic bclk_s, bclk_rise, bclk_fall;
  logic lrck_s, lrck_rise_raw, lrck_fall_raw;
  logic dat_s, dat_rise, dat_fall;

  codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .rst(rst), .din(aud_bclk),
    .dout(bclk_s), .rise(bclk_rise), .fall(bclk_fall)
  );
  codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk(clk), .rst(rst), .din(aud_adclrck),
    .dout(lrck_s), .rise(lrck_rise_raw), .fall(lrck_fall_raw)
  );
  codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .rst(rst), .din(aud_adcdat),
    .dout(dat_s), .rise(dat_rise), .fall(dat_fall)
  );

  // Only the BCLK rise is a timing event; LRCK and data are used as levels
  // sampled at that rise, so the remaining edge pulses are intentionally idle.
  logic unused_edges;
  assign unused_edges = ^{bclk_s, bclk_fall, lrck_rise_raw, lrck_fall_raw, dat_rise, dat_fall};

  // LRCK edges only count when observed at a BCLK rise, so LRCK is compared
  // against its value at the previous BCLK rise rather than the previous clk.
  logic lrck_prev_reg;
  logic lrck_edge, lrck_fall;
  assign lrck_edge = bclk_rise && (lrck_s != lrck_prev_reg);
  assign lrck_fall = lrck_edge && !lrck_s;

  // ---------------- receive FSM ----------------
  rx_state_t               state_reg, state_next;
  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [SKIP_W-1:0]       skip_cnt_reg, skip_cnt_next;
  logic [SAMPLE_WIDTH-1:0] shift_reg, shift_next;
  logic                    ch_reg, ch_next;
  logic [SAMPLE_WIDTH-1:0] word_reg, word_next;
  logic                    word_ch_reg, word_ch_next;
  logic                    store_reg, store_next;
  logic                    short_next;
  logic                    start_word;
  logic [SAMPLE_WIDTH-1:0] bit_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      skip_cnt_reg  <= '0;
      shift_reg     <= '0;
      ch_reg        <= CH_LEFT;
      lrck_prev_reg <= 1'b0;
      word_reg      <= '0;
      word_ch_reg   <= CH_LEFT;
      store_reg     <= 1'b0;
      short_word    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      skip_cnt_reg <= skip_cnt_next;
      shift_reg    <= shift_next;
      ch_reg       <= ch_next;
      word_reg     <= word_next;
      word_ch_reg  <= word_ch_next;
      store_reg    <= store_next;
      short_word   <= short_next;
      if (bclk_rise) lrck_prev_reg <= lrck_s;
    end
  end

  // Bits are written straight into their final position (MSB first) into a
  // cleared register, so a truncated word is already left-aligned with zero LSBs.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    skip_cnt_next = skip_cnt_reg;
    shift_next    = shift_reg;
    ch_next       = ch_reg;
    word_next     = word_reg;
    word_ch_next  = word_ch_reg;
    store_next    = 1'b0;
    short_next    = 1'b0;
    start_word    = 1'b0;
    bit_mask      = MSB_MASK >> bit_cnt_reg;

    if (!enable) begin
      state_next    = IDLE;
      bit_cnt_next  = '0;
      skip_cnt_next = '0;
      shift_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (lrck_fall) start_word = 1'b1;
        end
        SKIP, SHIFT: begin
          if (lrck_edge) begin
            store_next   = 1'b1;
            short_next   = 1'b1;
            word_next    = shift_reg;
            word_ch_next = ch_reg;
            start_word   = 1'b1;
          end else if (bclk_rise) begin
            if (state_reg == SKIP && skip_cnt_reg != SKIP_W'(I2S_DELAY)) begin
              skip_cnt_next = skip_cnt_reg + SKIP_W'(1);
            end else begin
              shift_next   = dat_s ? (shift_reg | bit_mask) : shift_reg;
              bit_cnt_next = bit_cnt_reg + CNT_W'(1);
              state_next   = SHIFT;
              if (bit_cnt_reg == CNT_W'(SAMPLE_WIDTH - 1)) begin
                store_next   = 1'b1;
                word_next    = shift_next;
                word_ch_next = ch_reg;
                state_next   = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (lrck_edge) start_word = 1'b1;
        end
        default: state_next = IDLE;
      endcase

      // The edge-detecting BCLK rise itself is the first skipped period; with
      // no delay that same rise already carries the MSB.
      if (start_word) begin
        ch_next       = lrck_s;
        shift_next    = '0;
        bit_cnt_next  = '0;
        skip_cnt_next = SKIP_W'(1);
        state_next    = SKIP;
        if (I2S_DELAY == 0) begin
          shift_next    = {dat_s, {(SAMPLE_WIDTH-1){1'b0}}};
          bit_cnt_next  = CNT_W'(1);
          skip_cnt_next = '0;
          state_next    = SHIFT;
        end
      end
    end
  end

  // ---------------- frame assembly and output ----------------
  logic [SAMPLE_WIDTH-1:0] left_hold_reg;
  logic                    have_left_reg;
  logic                    frame_done;

  assign frame_done = store_reg && (word_ch_reg == CH_RIGHT) && have_left_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_hold_reg <= '0;
      have_left_reg <= 1'b0;
      frame_left    <= '0;
      frame_right   <= '0;
      frame_valid   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      // A right word only pairs with a left word received since the last IDLE.
      if (!enable) begin
        have_left_reg <= 1'b0;
      end else if (store_reg) begin
        if (word_ch_reg == CH_LEFT) begin
          left_hold_reg <= word_reg;
          have_left_reg <= 1'b1;
        end else begin
          have_left_reg <= 1'b0;
        end
      end

      if (frame_done && (!frame_valid || frame_ready)) begin
        frame_left  <= left_hold_reg;
        frame_right <= word_reg;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      // A new drop wins over a simultaneous clear.
      if (frame_done && frame_valid && !frame_ready) overrun <= 1'b1;
      else if (overrun_clr)                           overrun <= 1'b0;
    end
  end

`ifdef LEVEL_METER_EN
  // ---------------- peak level meter ----------------
  logic [SAMPLE_WIDTH-1:0] word_abs;
  logic [SAMPLE_WIDTH-1:0] peak_reg;

  // The most negative value has no positive twin; clamp it to full scale.
  always_comb begin
    word_abs = word_reg;
    if (word_reg[SAMPLE_WIDTH-1]) begin
      if (word_reg == MSB_MASK) word_abs = ~MSB_MASK;
      else                      word_abs = (~word_reg) + SAMPLE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_reg   <= '0;
      peak_level <= '0;
    end else if (peak_rd) begin
      peak_level <= peak_reg;
      peak_reg   <= store_reg ? word_abs : '0;
    end else if (store_reg && (word_abs > peak_reg)) begin
      peak_reg <= word_abs;
    end
  end
`endif

endmodule
